// File: rtl/debug_uart_fifo.sv
// Memory-mapped debug UART: TX FIFO, programmable baud divider, status/irq.
// Optional receiver compiled in when DEBUG_UART_RX_EN is defined.
module debug_uart_fifo #(
  parameter int CLOCK_MHZ = 27,
  parameter int BIT_RATE  = 1_000_000,
  parameter int TX_DEPTH  = 8,
  parameter int DIV_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(CLOCK_MHZ*1_000_000/BIT_RATE - 1);

  // Bus handshake: an access is any data_*_n value other than 2'b11 and always
  // completes in the cycle it is presented; data_ready is permanently high.
  logic       wr_en, rd_en, status_wr;
  logic [1:0] reg_sel;

  assign wr_en      = (data_write_n != 2'b11);
  assign rd_en      = (data_read_n != 2'b11);
  assign reg_sel    = addr_in[3:2];
  assign status_wr  = wr_en && (reg_sel == 2'd1);
  assign data_ready = 1'b1;

  logic unused_bus;
  assign unused_bus = ^{addr_in[1:0], data_in[31:8]};

  logic [DIV_W-1:0] div_q;
  logic             tx_empty_ie, tx_ovf;
  logic             rx_valid, rx_ovr, rx_ie;
  logic [7:0]       rx_byte;

  // TX FIFO
  logic [7:0]  mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   tx_count;
  logic          fifo_empty, fifo_full, push_req, push_ok, tx_pop;

  assign fifo_empty = (tx_count == '0);
  assign fifo_full  = (tx_count == DEPTH_C);
  assign push_req   = wr_en && (reg_sel == 2'd0);
  // A simultaneous pop frees the slot, so a push at full is still accepted.
  assign push_ok    = push_req && (!fifo_full || tx_pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, tx_pop})
        2'b10:   tx_count <= tx_count + (AW+1)'(1);
        2'b01:   tx_count <= tx_count - (AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= RESET_DIV;
      tx_empty_ie <= 1'b0;
      tx_ovf      <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == 2'd2)) div_q <= data_in[DIV_W-1:0];
      if (wr_en && (reg_sel == 2'd3)) tx_empty_ie <= data_in[0];
      if (status_wr && data_in[4]) tx_ovf <= 1'b0;
      if (push_req && !push_ok) tx_ovf <= 1'b1;
    end
  end

  // TX state machine
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t        tx_state, tx_state_nx;
  logic [DIV_W-1:0] div_lat, tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             bit_done, tx_busy;

  assign bit_done = (tx_cnt == div_lat);
  assign tx_busy  = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_nx = tx_state;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE: if (!fifo_empty) begin
        tx_state_nx = TX_START;
        tx_pop      = 1'b1;
      end
      TX_START: if (bit_done) tx_state_nx = TX_DATA;
      TX_DATA:  if (bit_done && (tx_bit == 3'd7)) tx_state_nx = TX_STOP;
      TX_STOP: if (bit_done) begin
        if (!fifo_empty) begin
          tx_state_nx = TX_START;
          tx_pop      = 1'b1;
        end else begin
          tx_state_nx = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nx;
  end

  // Byte and divider are captured at frame start so mid-frame DIV writes wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= 8'h00;
      div_lat  <= '0;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
    end else if (tx_pop) begin
      tx_shift <= mem[rd_ptr];
      div_lat  <= div_q;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
    end else if (tx_busy) begin
      if (bit_done) begin
        tx_cnt <= '0;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + DIV_W'(1);
      end
    end
  end

  assign uart_txd = (tx_state == TX_START) ? 1'b0 :
                    (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

`ifdef DEBUG_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t        rx_state, rx_state_nx;
  logic [1:0]       rx_sync;
  logic             rxd_s, rxd_prev, rx_done, data_rd;
  logic [DIV_W-1:0] rx_cnt;
  logic [DIV_W:0]   rx_half;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_half_hit, rx_bit_done;

  assign rxd_s       = rx_sync[1];
  assign data_rd     = rd_en && (reg_sel == 2'd0);
  assign rx_half     = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
  assign rx_half_hit = ({1'b0, rx_cnt} == rx_half);
  assign rx_bit_done = (rx_cnt == div_q);

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxd_prev && !rxd_s) rx_state_nx = RX_START;
      RX_START: if (rx_half_hit) rx_state_nx = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_done && (rx_bit == 3'd7)) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_bit_done) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nx;
  end

  // After the half-bit start check the counter runs full bit periods, so every
  // later sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rxd_prev <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_done  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rxd};
      rxd_prev <= rxd_s;
      rx_done  <= (rx_state == RX_STOP) && rx_bit_done && rxd_s;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= 3'd0;
        end
        RX_START: rx_cnt <= rx_half_hit ? '0 : rx_cnt + DIV_W'(1);
        RX_DATA: begin
          if (rx_bit_done) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        default: rx_cnt <= rx_bit_done ? '0 : rx_cnt + DIV_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ie    <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == 2'd3)) rx_ie <= data_in[1];
      if (status_wr && data_in[5]) rx_ovr <= 1'b0;
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid) rx_ovr <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_valid   = 1'b0;
  assign rx_ovr     = 1'b0;
  assign rx_ie      = 1'b0;
  assign rx_byte    = 8'h00;
`endif

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      2'd0: rd_mux = {24'h0, rx_byte};
      2'd1: rd_mux = {16'h0, 8'(tx_count), 2'b00, rx_ovr, tx_ovf,
                      rx_valid, fifo_full, fifo_empty, tx_busy};
      2'd2: rd_mux = 32'(div_q);
      default: rd_mux = {30'h0, rx_ie, tx_empty_ie};
    endcase
  end

  assign data_out = rd_en ? rd_mux : 32'h0;
  assign irq = (tx_empty_ie & fifo_empty & ~tx_busy) | (rx_ie & rx_valid);

endmodule
